mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the 5-stage pipeline. It executes mult, multu, div and divu beside the combinational ALU in EX and writes the 64-bit result into architectural HI/LO. It takes one bit per cycle, so the hazard unit stalls on busy. It also serves mthi/mtlo writes; the core reads HI/LO combinationally for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_step.sv | 21 ++
 rtl/mul_div_unit.sv | 131 +++++++++++++
 tb/tb_mul_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus the iteration count and counter width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int ITER      = MDU_WIDTH;
  localparam int CNT_W     = $clog2(ITER);

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide step: try to subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   partial,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] diff;

  // partial < 2*divisor always holds, so the borrow shows up in bit W.
  always_comb begin
    diff     = partial - {1'b0, divisor};
    q_bit    = ~diff[W];
    rem_next = q_bit ? diff[W-1:0] : partial[W-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative mult/multu/div/divu unit owning architectural HI/LO; one result
// bit per cycle, with mthi/mtlo writes and pipeline-flush cancel.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       dbg_state
);

  mdu_state_e state, state_next;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand_b;
  logic               is_div_q, neg_res, neg_rem, dz;

  logic               accept, b_zero_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // Handshake: start is a request qualified only in IDLE; busy is high from
  // the cycle after acceptance through FIX; done pulses for the single cycle
  // after FIX in which HI/LO hold the new result.
  assign accept     = (state == IDLE) && start && !cancel;
  assign b_zero_div = op_is_div(op) && (B == '0);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  assign a_neg = op_is_signed(op) & A[WIDTH-1];
  assign b_neg = op_is_signed(op) & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? operand_b : {WIDTH{1'b0}})};

  mdu_div_step #(.W(WIDTH)) u_div_step (
    .partial  (acc[2*WIDTH-1:WIDTH-1]),
    .divisor  (operand_b),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_raw  = acc[WIDTH-1:0];
  assign rem_raw  = acc[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg_res ? -quo_raw : quo_raw;
  assign rem_fix  = neg_rem ? -rem_raw : rem_raw;
  assign prod_fix = neg_res ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = b_zero_div ? FIX : RUN;
      RUN:     if (cnt == CNT_W'(ITER - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cancel && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      operand_b <= '0;
      is_div_q  <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dz        <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state == RUN && state_next == RUN) cnt <= cnt + 1'b1;
      else                                   cnt <= '0;

      if (accept) begin
        is_div_q  <= op_is_div(op);
        neg_res   <= a_neg ^ b_neg;
        neg_rem   <= a_neg;
        dz        <= b_zero_div;
        operand_b <= b_mag;
        // Divide by zero parks the final {hi,lo} in acc right away.
        acc <= b_zero_div ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
      end else if (state == RUN) begin
        acc <= is_div_q ? {rem_next, acc[WIDTH-2:0], q_bit}
                        : {mul_sum, acc[WIDTH-1:1]};
      end

      if (state == FIX && !cancel) begin
        if (dz)            {hi, lo} <= acc;
        else if (is_div_q) begin
          lo <= quo_fix;
          hi <= rem_fix;
        end else           {hi, lo} <= prod_fix;
        done <= 1'b1;
      end else if (state == IDLE && !start && !done) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic
// reference model of the HI/LO results and cycle timing.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  mdu_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_model(input logic [1:0] o,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [2*W-1:0] ux, uy;
    if (o[1] && y == '0) return {x, {W{1'b1}}};
    case (o)
      2'b00: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx * sy;
        return q;
      end
      2'b01: begin
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        return ux * uy;
      end
      2'b10: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[W-1:0], q[W-1:0]};
      end
      default: return {x % y, x / y};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    start = 0; cancel = 0; wr_hi = 0; wr_lo = 0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
  endtask

  task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    wr_hi = 1; wdata = h; tick(); wr_hi = 0;
    wr_lo = 1; wdata = l; tick(); wr_lo = 0;
  endtask

  // Launches one op and follows it to done; wr_cycle>0 pokes an mtlo while busy.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input int wr_cycle);
    int cyc, lat, busy_bad;
    logic [2*W-1:0] exp;
    exp_q.push_back(ref_model(o, x, y));
    lat = (o[1] && y == '0) ? 2 : ITER + 2;
    start = 1; op = o; a = x; b = y;
    tick();
    start = 0; a = $urandom; b = $urandom;
    cyc = 1; busy_bad = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_bad++;
      wr_lo = (cyc == wr_cycle);
      wdata = 32'hDEAD_0000 | cyc;
      tick();
      cyc++;
    end
    wr_lo = 0;
    exp = exp_q.pop_front();
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_busy_run"}, busy_bad, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_hilo"}, {hi, lo}, exp);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_state", dbg_state, IDLE);

    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_k", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    check("mult_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_k", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_z", MDU_DIVU, 32'h1234, 32'd0, 0);
    check("divu_z_k", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op("div_z", MDU_DIV, 32'h8765_4321, 32'd0, 0);

    // cancel mid-operation; a second start while busy is ignored
    write_hilo(32'h11, 32'h22);
    start = 1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
    tick();
    for (int c = 1; c < 10; c++) begin
      start = (c == 5);
      op = MDU_MULTU; a = 32'd5; b = 32'd5;
      tick();
    end
    start = 0; cancel = 1;
    tick();
    cancel = 0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    check("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    check("cancel_quiet", done_cnt, 0);
    check("cancel_hilo_late", {hi, lo}, {32'h11, 32'h22});

    // start+cancel in IDLE is refused and a same-cycle mthi is ignored
    start = 1; cancel = 1; wr_hi = 1; wdata = 32'h5555_5555;
    op = MDU_MULTU; a = 32'd3; b = 32'd3;
    tick();
    start = 0; cancel = 0; wr_hi = 0;
    check("startcancel_busy", busy, 0);
    check("startcancel_hi", hi, 32'h11);

    // mthi/mtlo together, then mtlo during busy is dropped
    wr_hi = 1; wr_lo = 1; wdata = 32'hCAFE_BABE;
    tick();
    wr_hi = 0; wr_lo = 0;
    check("mtx_both", {hi, lo}, {32'hCAFE_BABE, 32'hCAFE_BABE});
    run_op("divu_wrbusy", MDU_DIVU, 32'd100, 32'd7, 3);
    check("divu_wrbusy_k", {hi, lo}, {32'd2, 32'd14});

    // reset in cycle 20 of a multu
    start = 1; op = MDU_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    tick();
    start = 0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1;
    tick();
    rst = 0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hilo", {hi, lo}, 0);
    tick(); tick();
    run_op("after_rst", MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op("rand", ro, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
